// File: rtl/i2c_reg_responder.sv
// I2C target emulating a byte-addressed register file, with a write strobe and a local read port.
// Define I2C_GLITCH_FILTER_EN to debounce the synchronized SCL/SDA over FILT_LEN cycles.
module i2c_reg_responder #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h39,
  parameter int unsigned REG_DEPTH  = 256,
  parameter int unsigned FILT_LEN   = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_OE,
  output logic       oBUSY,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  input  logic [7:0] iRD_ADDR,
  output logic [7:0] oRD_DATA
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl, w_sda;
  logic       r_scl_d, r_sda_d;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], iSCL};
      r_sda_sync <= {r_sda_sync[0], iSDA};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned FCW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [FCW-1:0] r_scl_cnt, r_sda_cnt;
  logic           r_scl_flt, r_sda_flt;

  // A new level is taken only after FILT_LEN consecutive samples disagree with the held one.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
      r_scl_flt <= 1'b1;
      r_sda_flt <= 1'b1;
    end else begin
      if (r_scl_sync[1] == r_scl_flt) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FCW'(FILT_LEN - 1)) begin
        r_scl_flt <= r_scl_sync[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 1'b1;
      end
      if (r_sda_sync[1] == r_sda_flt) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FCW'(FILT_LEN - 1)) begin
        r_sda_flt <= r_sda_sync[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  // FILT_LEN only sizes the optional filter.
  if (FILT_LEN == 0) begin : g_no_filter
  end

  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_oe, w_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_stb, w_stb_nxt;
  logic [7:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       w_we;
  logic [7:0] w_ptr_inc, w_ptr_load, w_rd_byte;
  logic [7:0] r_regs [REG_DEPTH];
  logic [7:0] r_rd_data;

  assign w_ptr_inc  = (r_ptr == 8'(REG_DEPTH - 1)) ? '0 : r_ptr + 8'd1;
  assign w_ptr_load = 8'(32'(r_shift) % REG_DEPTH);
  assign w_rd_byte  = r_regs[r_ptr];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_stb     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_oe      <= w_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_rw      <= w_rw_nxt;
      r_stb     <= w_stb_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;
    w_oe_nxt      = r_oe;
    w_busy_nxt    = r_busy;
    w_rw_nxt      = r_rw;
    w_stb_nxt     = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_we          = 1'b0;
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = '0;
    end else if (w_start) begin
      w_state_nxt = ADDR;
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: ;
        // Incoming bytes complete on the SCL fall after bit 8, which also opens the ACK slot.
        ADDR, PTR, WDATA: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt_nxt = '0;
            if (r_state == ADDR) begin
              if (r_shift[7:1] == SLAVE_ADDR) begin
                w_state_nxt = ADDR_ACK;
                w_oe_nxt    = 1'b1;
                w_busy_nxt  = 1'b1;
                w_rw_nxt    = r_shift[0];
              end else begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
              end
            end else if (r_state == PTR) begin
              w_ptr_nxt   = w_ptr_load;
              w_state_nxt = PTR_ACK;
              w_oe_nxt    = 1'b1;
            end else begin
              w_we          = 1'b1;
              w_stb_nxt     = 1'b1;
              w_wr_addr_nxt = r_ptr;
              w_wr_data_nxt = r_shift;
              w_ptr_nxt     = w_ptr_inc;
              w_state_nxt   = WDATA_ACK;
              w_oe_nxt      = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_shift_nxt = w_rd_byte;
              w_oe_nxt    = ~w_rd_byte[7];
              w_ptr_nxt   = w_ptr_inc;
              w_cnt_nxt   = '0;
              w_state_nxt = RDATA;
            end else begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (w_scl_fall) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = WDATA;
          end
        end
        RDATA: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd7) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = RDATA_ACK;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
              w_cnt_nxt   = r_cnt + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (w_scl_rise && w_sda) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end else if (w_scl_fall) begin
            w_shift_nxt = w_rd_byte;
            w_oe_nxt    = ~w_rd_byte[7];
            w_ptr_nxt   = w_ptr_inc;
            w_cnt_nxt   = '0;
            w_state_nxt = RDATA;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_we) r_regs[r_ptr] <= r_shift;
      r_rd_data <= r_regs[iRD_ADDR];
    end
  end

  assign oSDA_OE  = r_oe;
  assign oBUSY    = r_busy;
  assign oWR_STB  = r_stb;
  assign oWR_ADDR = r_wr_addr;
  assign oWR_DATA = r_wr_data;
  assign oRD_DATA = r_rd_data;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: bit-banged I2C master, register-file model and write scoreboard.
`timescale 1ns/1ps
module tb_i2c_reg_responder;
  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       oe, busy, stb;
  logic [7:0] wa, wd, rd_addr, rd_data;

  assign sda_line = m_sda & ~oe;

  always #10 clk = ~clk;

  i2c_reg_responder #(.SLAVE_ADDR(7'h39), .REG_DEPTH(256), .FILT_LEN(4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSCL(m_scl), .iSDA(sda_line),
    .oSDA_OE(oe), .oBUSY(busy), .oWR_STB(stb), .oWR_ADDR(wa), .oWR_DATA(wd),
    .iRD_ADDR(rd_addr), .oRD_DATA(rd_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_q[$];
  wr_t        e;
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr = '0;
  logic [7:0] rd_pend;
  bit         rd_pend_v = 0;
  bit         silent = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      rd_pend_v = 0;
      check("rst_oe", oe, 0);
    end else begin
      if (rd_pend_v) check("rd_data", rd_data, rd_pend);
      if (silent) check("silent_oe", oe, 0);
      if (stb) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: addr %0h data %0h, expected no strobe", wa, wd);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wa, e.a);
          check("wr_data", wd, e.d);
          m_mem[e.a] = e.d;
        end
      end
      rd_pend   = m_mem[rd_addr];
      rd_pend_v = 1;
    end
  end

  task automatic wq(input int n = 1);
    repeat (n * Q) @(posedge clk);
    #2;
  endtask

  task automatic bit_out(input logic b);
    m_sda = b; wq(); m_scl = 1'b1; wq(2); m_scl = 1'b0; wq();
  endtask

  task automatic bit_in(output logic b);
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); b = sda_line; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq(2);
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string name);
    logic ack;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(ack);
    check(name, ack, exp_ack);
  endtask

  task automatic data_wr(input logic [7:0] b);
    exp_q.push_back('{a: m_ptr, d: b});
    m_ptr = m_ptr + 8'd1;
    send(b, 1'b0, "wdata_ack");
  endtask

  task automatic data_rd(input logic nack, input logic [7:0] lit, input string name);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(nack);
    check(name, d, lit);
    check({name, "_model"}, d, m_mem[m_ptr]);
    m_ptr = m_ptr + 8'd1;
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] lit, input string name);
    @(posedge clk); #2;
    rd_addr = a;
    repeat (3) @(posedge clk);
    #2;
    check(name, rd_data, lit);
  endtask

  initial begin
    logic ack;
    rd_addr = '0;
    repeat (5) @(posedge clk);
    #2;
    check("rst_sda_oe", oe, 0);
    check("rst_busy", busy, 0);
    check("rst_stb", stb, 0);
    check("rst_wr_addr", wa, 0);
    check("rst_wr_data", wd, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    wq();

    // single write
    i2c_start();
    send(8'h72, 1'b0, "t1_addr_ack");
    check("t1_busy", busy, 1);
    send(8'h98, 1'b0, "t1_ptr_ack");
    m_ptr = 8'h98;
    data_wr(8'h03);
    i2c_stop();
    check("t1_busy_after_stop", busy, 0);
    peek(8'h98, 8'h03, "t1_reg98");

    // burst write across the pointer wrap
    i2c_start();
    send(8'h72, 1'b0, "t2_addr_ack");
    send(8'hFE, 1'b0, "t2_ptr_ack");
    m_ptr = 8'hFE;
    data_wr(8'h11);
    data_wr(8'h22);
    data_wr(8'h33);
    i2c_stop();
    peek(8'h00, 8'h33, "t2_reg00_wrap");
    peek(8'hFF, 8'h22, "t2_regFF");

    // preload, then pointer write + repeated START + read ACK/NACK
    i2c_start();
    send(8'h72, 1'b0, "t3_addr_ack");
    send(8'h41, 1'b0, "t3_ptr_ack");
    m_ptr = 8'h41;
    data_wr(8'hA5);
    data_wr(8'h5A);
    i2c_stop();
    i2c_start();
    send(8'h72, 1'b0, "t3_addr2_ack");
    send(8'h41, 1'b0, "t3_ptr2_ack");
    m_ptr = 8'h41;
    i2c_start();
    send(8'h73, 1'b0, "t3_raddr_ack");
    check("t3_busy_read", busy, 1);
    data_rd(1'b0, 8'hA5, "t3_rd0");
    data_rd(1'b1, 8'h5A, "t3_rd1");
    wq();
    check("t3_oe_after_nack", oe, 0);
    check("t3_busy_after_nack", busy, 0);
    i2c_stop();

    // wrong address: no ACK, bus never driven
    silent = 1;
    i2c_start();
    send(8'h74, 1'b1, "t4_nack");
    check("t4_busy", busy, 0);
    i2c_stop();
    silent = 0;

    // STOP after 4 data bits discards the partial byte
    i2c_start();
    send(8'h72, 1'b0, "t5_addr_ack");
    send(8'h10, 1'b0, "t5_ptr_ack");
    m_ptr = 8'h10;
    data_wr(8'h77);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    i2c_stop();
    peek(8'h10, 8'h77, "t5_partial_dropped");
    peek(8'h11, 8'h00, "t5_next_untouched");

    // reset asserted while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(ack_bit(i));
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq();
    check("t5_ack_driven", oe, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_release_now", oe, 0);
    wq();
    m_scl = 1'b0;
    wq();
    rst_n = 1'b1;
    m_ptr = '0;
    exp_q.delete();
    wq();
    i2c_start();
    send(8'h72, 1'b0, "t5_post_addr_ack");
    send(8'h20, 1'b0, "t5_post_ptr_ack");
    m_ptr = 8'h20;
    data_wr(8'h99);
    i2c_stop();
    peek(8'h20, 8'h99, "t5_post_reg20");
    peek(8'h10, 8'h00, "t5_reg10_cleared");

    // 2-cycle SDA glitch while SCL is high during the address byte
`ifndef I2C_GLITCH_FILTER_EN
    silent = 1;
`endif
    i2c_start();
    bit_out(1'b0);
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq();
    m_sda = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    m_sda = 1'b1; wq(); m_scl = 1'b0; wq();
    for (int i = 5; i >= 0; i--) bit_out(ack_bit(i));
    bit_in(ack);
`ifdef I2C_GLITCH_FILTER_EN
    check("t6_glitch_filtered_ack", ack, 0);
`else
    check("t6_glitch_aborts_nack", ack, 1);
    check("t6_busy", busy, 0);
`endif
    i2c_stop();
    silent = 0;
    check("t6_busy_after_stop", busy, 0);

    wq(2);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic ack_bit(input int i);
    logic [7:0] a;
    a = 8'h72;
    return a[i];
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
